alu_bitserial_seq: RTL and testbench



---
 rtl/alu_bitserial_seq.sv | 136 +++++++++++++
 tb/tb_alu_bitserial_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bitserial_seq.sv
// alu_bitserial_seq: bit-serial sequencer for a 1-bit ALU slice.
// Accepts an operand pair and opcode, then walks the external slice one bit
// per cycle (LSB first) with the carry chained through a register.
// Finally it presents the assembled result and flags on an output handshake.
module alu_bitserial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [1:0]       slice_sel,
  input  logic             slice_z,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_final;
  logic [1:0]       op_reg;
  logic [CW-1:0]    bit_cnt;
  logic             carry_reg;
  logic             carry_flag;
  logic             ovf_flag;
  logic             zero_flag;
  logic             running;
  logic             last_bit;
  logic             is_sub;
  logic             is_arith;

  assign running   = (state == RUN);
  assign last_bit  = running && (bit_cnt == CW'(WIDTH - 1));
  assign is_sub    = (op_reg == 2'b01);
  assign is_arith  = ~op_reg[1];
  assign res_final = {slice_z, res_sh[WIDTH-1:1]};

  // Slice drive is only live during RUN so the slice sees a quiet bus otherwise.
  assign slice_a   = running ? a_sh[0] : 1'b0;
  assign slice_b   = running ? (b_sh[0] ^ is_sub) : 1'b0;
  assign slice_cin = running ? carry_reg : 1'b0;
  assign slice_sel = running ? op_reg : 2'b00;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign result    = res_sh;
  assign carry     = carry_flag;
  assign overflow  = ovf_flag;
  assign zero      = zero_flag;

  // State register; reset wins over any handshake at the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: accept, run WIDTH bits, then hold until the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift one bit per RUN cycle, capture flags on the MSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      op_reg     <= 2'b00;
      bit_cnt    <= '0;
      carry_reg  <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh       <= in_a;
            b_sh       <= in_b;
            op_reg     <= in_op;
            bit_cnt    <= '0;
            carry_reg  <= (in_op == 2'b01);
            res_sh     <= '0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            zero_flag  <= 1'b0;
          end
        end
        RUN: begin
          res_sh    <= res_final;
          carry_reg <= slice_cout;
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          bit_cnt   <= bit_cnt + CW'(1);
          if (last_bit) begin
            carry_flag <= is_arith & slice_cout;
            ovf_flag   <= is_arith & (slice_cin ^ slice_cout);
            zero_flag  <= (res_final == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// tb_alu_bitserial_seq: directed bench for the bit-serial ALU sequencer.
// A behavioural 1-bit slice closes the loop; expected values are hand-computed.
module tb_alu_bitserial_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [1:0]       slice_sel;
  logic             slice_z;
  logic             slice_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  alu_bitserial_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sel  (slice_sel),
    .slice_z    (slice_z),
    .slice_cout (slice_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry      (carry),
    .overflow   (overflow),
    .zero       (zero),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice.
  always_comb begin
    slice_z    = 1'b0;
    slice_cout = 1'b0;
    case (slice_sel)
      2'b00, 2'b01: begin
        slice_z    = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
      end
      2'b10:   slice_z = slice_a & slice_b;
      default: slice_z = slice_a | slice_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
  endtask

  // Counts edges from the accepting edge until out_valid, bounded.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      check_slice_quiet_unless_run();
      tick();
      n++;
    end
    check_output({tag, "_latency"}, 32'(n), 32'd8);
  endtask

  task automatic check_slice_quiet_unless_run();
    if (!busy || out_valid)
      check_output("slice_quiet", {28'd0, slice_a, slice_b, slice_cin, slice_sel != 2'b00}, 32'd0);
  endtask

  task automatic check_flags(input string tag, input logic [WIDTH-1:0] res,
                             input logic c, input logic v, input logic z);
    check_output({tag, "_result"},   32'(result),   32'(res));
    check_output({tag, "_carry"},    32'(carry),    32'(c));
    check_output({tag, "_overflow"}, 32'(overflow), 32'(v));
    check_output({tag, "_zero"},     32'(zero),     32'(z));
  endtask

  task automatic handoff(input string tag);
    check_slice_quiet_unless_run();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_output({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check_output({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] res,
                        input logic c, input logic v, input logic z);
    apply_stimulus(op, a, b);
    tick();
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_op    = ~op;
    check_output({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(tag);
    check_flags(tag, res, c, v, z);
    handoff(tag);
  endtask

  // Directed sequence covering reset, each opcode, backpressure, abort and back-to-back.
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    check_output("rst_in_ready",  32'(in_ready),  32'd1);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_busy",      32'(busy),      32'd0);
    check_flags("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("[TB] arithmetic and logic ops");
    run_op("add_7f_01", 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("sub_05_05", 2'b01, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("sub_00_01", 2'b01, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("and_f0_3c", 2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);

    $display("[TB] backpressure");
    apply_stimulus(2'b11, 8'hF0, 8'h0F);
    tick();
    in_valid = 1'b0;
    wait_done("or_bp");
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(2'b00, 8'h11, 8'h22);
      in_valid = i[0];
      tick();
      check_output("bp_valid_hold", 32'(out_valid), 32'd1);
      check_output("bp_in_ready",   32'(in_ready),  32'd0);
      check_flags("bp", 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    handoff("or_bp");
    run_op("add_after_bp", 2'b00, 8'h3C, 8'h0A, 8'h46, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-run");
    apply_stimulus(2'b00, 8'hFF, 8'h01);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_output("abort_in_ready",  32'(in_ready),  32'd1);
    check_output("abort_out_valid", 32'(out_valid), 32'd0);
    check_output("abort_result",    32'(result),    32'd0);
    check_output("abort_busy",      32'(busy),      32'd0);
    run_op("add_after_abort", 2'b00, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back");
    apply_stimulus(2'b00, 8'h80, 8'h80);
    tick();
    apply_stimulus(2'b01, 8'h10, 8'h20);
    wait_done("b2b_first");
    check_output("b2b_first_in_ready", 32'(in_ready), 32'd0);
    check_flags("b2b_first", 8'h00, 1'b1, 1'b1, 1'b1);
    handoff("b2b_first");
    tick();
    in_valid = 1'b0;
    check_output("b2b_second_busy", 32'(busy), 32'd1);
    wait_done("b2b_second");
    check_flags("b2b_second", 8'hF0, 1'b0, 1'b0, 1'b0);
    handoff("b2b_second");
    check_output("idle_slice_sel", 32'(slice_sel), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
